// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : core_pkg                                                   |
// | Description : Shared types and constants for the multicycle core         |
// |               control path: controller state encoding, ARM condition     |
// |               codes, instruction class values and compare-class funct    |
// |               codes.                                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package core_pkg;

    // Controller sequencing states; the encoding is also exported on state_o.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXEC_DP   = 4'd3,
        ST_EXEC_ADDR = 4'd4,
        ST_MEM       = 4'd5,
        ST_WB_ALU    = 4'd6,
        ST_WB_MEM    = 4'd7,
        ST_BRANCH    = 4'd8
    } ctrl_state_e;

    // ARM condition field ir[31:28].
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Instruction class, ir[27:26]. 2'b11 is undefined.
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing functs that only set flags and never write Rd.
    localparam logic [3:0] FUNCT_TST = 4'b1000;
    localparam logic [3:0] FUNCT_TEQ = 4'b1001;
    localparam logic [3:0] FUNCT_CMP = 4'b1010;
    localparam logic [3:0] FUNCT_CMN = 4'b1011;

endpackage : core_pkg
`default_nettype wire

// File: rtl/condition_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : condition_unit                                             |
// | Description : Combinational ARM condition-code evaluator.                |
// |   cond_i [3:0] : condition field of the instruction                      |
// |   nzcv_i [3:0] : flags {N,Z,C,V}                                         |
// |   pass_o       : 1 when the instruction should execute                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module condition_unit
    import core_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = nzcv_i[3];
    assign w_z = nzcv_i[2];
    assign w_c = nzcv_i[1];
    assign w_v = nzcv_i[0];

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = w_z;
            COND_NE: pass_o = !w_z;
            COND_CS: pass_o = w_c;
            COND_CC: pass_o = !w_c;
            COND_MI: pass_o = w_n;
            COND_PL: pass_o = !w_n;
            COND_VS: pass_o = w_v;
            COND_VC: pass_o = !w_v;
            COND_HI: pass_o = w_c && !w_z;
            COND_LS: pass_o = !w_c || w_z;
            COND_GE: pass_o = (w_n == w_v);
            COND_LT: pass_o = (w_n != w_v);
            COND_GT: pass_o = !w_z && (w_n == w_v);
            COND_LE: pass_o = w_z || (w_n != w_v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;   // NV never executes
        endcase
    end

endmodule : condition_unit
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multicycle_controller                                      |
// | Description : Multicycle sequencing FSM. Fetches over a request/ready    |
// |               handshake, holds the instruction and NZCV flags, checks    |
// |               the condition field and steps the datapath through the     |
// |               per-class state sequence.                                  |
// |   clk, reset_ni        : clock, synchronous active-low reset             |
// |   instr_i, imem_ready_i: fetch data and its valid strobe                 |
// |   dmem_ready_i         : data access complete                            |
// |   alu_nzcv_i           : ALU flags for the instruction in EXEC_DP        |
// |   imem_req_o, dmem_req_o, dmem_we_o : memory requests                    |
// |   ir_o, ir_write_o     : instruction register and its load strobe        |
// |   pc_write_o, pc_src_o : PC load strobe and source (0 PC+4, 1 target)    |
// |   reg_write_o, wb_sel_o: register write enable, source (0 ALU, 1 mem)    |
// |   nzcv_o, state_o      : flags register, debug state                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multicycle_controller
    import core_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 0
)(
    input  logic        clk,
    input  logic        reset_ni,
    input  logic [31:0] instr_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    input  logic [3:0]  alu_nzcv_i,
    output logic        imem_req_o,
    output logic [31:0] ir_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        reg_write_o,
    output logic        wb_sel_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  nzcv_o,
    output logic [3:0]  state_o
);

    // Only IMEM_TIMEOUT = 0 (no fetch timeout) is supported; reject other values.
    generate
        if (IMEM_TIMEOUT != 0) begin : g_timeout_unsupported
            $error("multicycle_controller: IMEM_TIMEOUT must be 0");
        end
    endgenerate

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;
    logic [31:0] r_ir;
    logic [3:0]  r_nzcv;

    logic        w_cond_pass;
    logic        w_flags_load;
    logic        w_is_compare;
    logic [1:0]  w_class;
    logic [3:0]  w_funct;

    assign w_class = r_ir[27:26];
    assign w_funct = r_ir[24:21];

    // Compare-class ops update flags only; they skip the register write-back.
    assign w_is_compare = (w_funct == FUNCT_TST) || (w_funct == FUNCT_TEQ) ||
                          (w_funct == FUNCT_CMP) || (w_funct == FUNCT_CMN);

    condition_unit u_condition_unit (
        .cond_i (r_ir[31:28]),
        .nzcv_i (r_nzcv),
        .pass_o (w_cond_pass)
    );

    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
            r_ir    <= 32'h0000_0000;
            r_nzcv  <= 4'h0;
        end else begin
            r_state <= w_next_state;
            if (ir_write_o) begin
                r_ir <= instr_i;
            end
            if (w_flags_load) begin
                r_nzcv <= alu_nzcv_i;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_flags_load = 1'b0;
        imem_req_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        wb_sel_o     = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    // IR load and PC+4 happen on the same edge.
                    ir_write_o   = 1'b1;
                    pc_write_o   = 1'b1;
                    w_next_state = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (!w_cond_pass) begin
                    w_next_state = ST_FETCH;
                end else begin
                    case (w_class)
                        OP_DP:   w_next_state = ST_EXEC_DP;
                        OP_MEM:  w_next_state = ST_EXEC_ADDR;
                        OP_BR:   w_next_state = ST_BRANCH;
                        default: w_next_state = ST_FETCH;   // undefined class
                    endcase
                end
            end

            ST_EXEC_DP: begin
                w_flags_load = r_ir[20];
                w_next_state = w_is_compare ? ST_FETCH : ST_WB_ALU;
            end

            ST_WB_ALU: begin
                reg_write_o  = 1'b1;
                w_next_state = ST_FETCH;
            end

            ST_EXEC_ADDR: begin
                w_next_state = ST_MEM;
            end

            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = !r_ir[20];
                if (dmem_ready_i) begin
                    w_next_state = r_ir[20] ? ST_WB_MEM : ST_FETCH;
                end
            end

            ST_WB_MEM: begin
                reg_write_o  = 1'b1;
                wb_sel_o     = 1'b1;
                w_next_state = ST_FETCH;
            end

            ST_BRANCH: begin
                pc_write_o   = 1'b1;
                pc_src_o     = 1'b1;
                w_next_state = ST_FETCH;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign ir_o    = r_ir;
    assign nzcv_o  = r_nzcv;
    assign state_o = r_state;

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multicycle_controller                                   |
// | Description : Self-checking bench for multicycle_controller. A per-cycle |
// |               vector table drives inputs and lists the expected state,   |
// |               strobes and flags; a condition-code sequence follows.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multicycle_controller;
    import core_pkg::*;

    localparam logic [31:0] c_ADDS   = 32'hE092_1003;   // ADDS R1,R2,R3
    localparam logic [31:0] c_ADDSNV = 32'hF092_1003;   // same, cond NV
    localparam logic [31:0] c_CMP    = 32'hE351_0000;   // CMP R1,#0
    localparam logic [31:0] c_BEQ    = 32'h0A00_0002;
    localparam logic [31:0] c_LDR    = 32'hE592_1000;
    localparam logic [31:0] c_STR    = 32'hE582_1000;
    localparam logic [31:0] c_UNDEF  = 32'hEC00_0000;   // class 11

    // strobe vector: {imem_req, ir_write, pc_write, pc_src,
    //                 reg_write, wb_sel, dmem_req, dmem_we}
    localparam logic [7:0] c_NONE  = 8'h00;
    localparam logic [7:0] c_FWAIT = 8'h80;
    localparam logic [7:0] c_FRDY  = 8'hE0;
    localparam logic [7:0] c_BR    = 8'h30;
    localparam logic [7:0] c_WBA   = 8'h08;
    localparam logic [7:0] c_WBM   = 8'h0C;
    localparam logic [7:0] c_MLD   = 8'h02;
    localparam logic [7:0] c_MST   = 8'h03;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [31:0] instr_i;
    logic        imem_ready_i;
    logic        dmem_ready_i;
    logic [3:0]  alu_nzcv_i;
    logic        imem_req_o;
    logic [31:0] ir_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic        pc_src_o;
    logic        reg_write_o;
    logic        wb_sel_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  nzcv_o;
    logic [3:0]  state_o;
    logic [7:0]  strb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.IMEM_TIMEOUT(0)) dut (
        .clk          (clk),
        .reset_ni     (reset_ni),
        .instr_i      (instr_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .alu_nzcv_i   (alu_nzcv_i),
        .imem_req_o   (imem_req_o),
        .ir_o         (ir_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .reg_write_o  (reg_write_o),
        .wb_sel_o     (wb_sel_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .nzcv_o       (nzcv_o),
        .state_o      (state_o)
    );

    assign strb = {imem_req_o, ir_write_o, pc_write_o, pc_src_o,
                   reg_write_o, wb_sel_o, dmem_req_o, dmem_we_o};

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        iready;
        logic        dready;
        logic [3:0]  anzcv;
        ctrl_state_e st;
        logic [7:0]  strb;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic [31:0] instr,
                                input logic iready, input logic dready,
                                input logic [3:0] anzcv, input ctrl_state_e st,
                                input logic [7:0] s, input logic [3:0] nzcv);
        vec_t v;
        v.rst_n = rst_n; v.instr = instr; v.iready = iready; v.dready = dready;
        v.anzcv = anzcv; v.st = st; v.strb = s; v.nzcv = nzcv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic [31:0] instr, input logic iready,
                         input logic dready, input logic [3:0] anzcv);
        reset_ni     = rst_n;
        instr_i      = instr;
        imem_ready_i = iready;
        dmem_ready_i = dready;
        alu_nzcv_i   = anzcv;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Flags are set with a CMP whose ALU result is 'flags', then a branch with
    // condition 'cond' must either reach BRANCH or fall back to FETCH.
    task automatic run_cond(input logic [3:0] flags, input logic [3:0] cond, input logic pass);
        logic [31:0] br;
        br = {cond, 28'hA00_0002};
        drive(1'b1, c_CMP, 1'b1, 1'b0, 4'h0);
        #2 check("cond_fetch_state", 32'(state_o), 32'(ST_FETCH));
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0, flags);
        tick();
        drive(1'b1, br, 1'b1, 1'b0, 4'h0);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0);
        #2;
        check("cond_flags", 32'(nzcv_o), 32'(flags));
        check("cond_ir", ir_o, br);
        tick();
        #2 check($sformatf("cond_%0h_flags_%0h", cond, flags), 32'(state_o),
                 pass ? 32'(ST_BRANCH) : 32'(ST_FETCH));
        if (pass) begin
            check("cond_branch_pcsrc", 32'(pc_src_o), 32'd1);
            tick();
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0);
        tick();

        // reset rows (two more reset edges) and release
        vecs.push_back(mk(0, 32'h0,    0, 0, 4'h0, ST_IDLE,      c_NONE,  4'h0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 4'h0, ST_IDLE,      c_NONE,  4'h0));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_IDLE,      c_NONE,  4'h0));
        // ADDS: 4 cycles, flags 0100, one reg write from ALU
        vecs.push_back(mk(1, c_ADDS,   1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h0));
        vecs.push_back(mk(1, 32'h0,    1, 1, 4'h0, ST_DECODE,    c_NONE,  4'h0));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h4, ST_EXEC_DP,   c_NONE,  4'h0));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_WB_ALU,    c_WBA,   4'h4));
        // CMP with one fetch wait, flags 0110 (Z set)
        vecs.push_back(mk(1, c_CMP,    0, 0, 4'h0, ST_FETCH,     c_FWAIT, 4'h4));
        vecs.push_back(mk(1, c_CMP,    1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h4));
        vecs.push_back(mk(1, 32'h0,    1, 0, 4'h0, ST_DECODE,    c_NONE,  4'h4));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h6, ST_EXEC_DP,   c_NONE,  4'h4));
        // BEQ taken
        vecs.push_back(mk(1, c_BEQ,    1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h6));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_DECODE,    c_NONE,  4'h6));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_BRANCH,    c_BR,    4'h6));
        // CMP clearing Z, BEQ not taken
        vecs.push_back(mk(1, c_CMP,    1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h6));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_DECODE,    c_NONE,  4'h6));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h2, ST_EXEC_DP,   c_NONE,  4'h6));
        vecs.push_back(mk(1, c_BEQ,    1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_DECODE,    c_NONE,  4'h2));
        // LDR with dmem ready delayed 3 cycles: 8 cycles total
        vecs.push_back(mk(1, c_LDR,    1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 1, 4'h0, ST_DECODE,    c_NONE,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 1, 4'h0, ST_EXEC_ADDR, c_NONE,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_MEM,       c_MLD,   4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_MEM,       c_MLD,   4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_MEM,       c_MLD,   4'h2));
        vecs.push_back(mk(1, 32'h0,    1, 1, 4'h0, ST_MEM,       c_MLD,   4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_WB_MEM,    c_WBM,   4'h2));
        // STR, zero wait, back to FETCH without register write
        vecs.push_back(mk(1, c_STR,    1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 1, 4'h0, ST_DECODE,    c_NONE,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 1, 4'h0, ST_EXEC_ADDR, c_NONE,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 1, 4'h0, ST_MEM,       c_MST,   4'h2));
        // NV and undefined class both fall straight back to FETCH
        vecs.push_back(mk(1, c_ADDSNV, 1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_DECODE,    c_NONE,  4'h2));
        vecs.push_back(mk(1, c_UNDEF,  1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_DECODE,    c_NONE,  4'h2));
        // reset while a store is pending in MEM
        vecs.push_back(mk(1, c_STR,    1, 0, 4'h0, ST_FETCH,     c_FRDY,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_DECODE,    c_NONE,  4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_EXEC_ADDR, c_NONE,  4'h2));
        vecs.push_back(mk(0, 32'h0,    0, 0, 4'h0, ST_MEM,       c_MST,   4'h2));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_IDLE,      c_NONE,  4'h0));
        vecs.push_back(mk(1, 32'h0,    0, 0, 4'h0, ST_FETCH,     c_FWAIT, 4'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].instr, vecs[i].iready, vecs[i].dready, vecs[i].anzcv);
            #2;
            check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("vec%0d_strobes", i), 32'(strb), 32'(vecs[i].strb));
            check($sformatf("vec%0d_nzcv", i), 32'(nzcv_o), 32'(vecs[i].nzcv));
            tick();
        end

        // condition codes (flags are {N,Z,C,V})
        run_cond(4'b0000, 4'h1, 1'b1);   // NE
        run_cond(4'b0010, 4'h2, 1'b1);   // CS
        run_cond(4'b0010, 4'h3, 1'b0);   // CC
        run_cond(4'b1000, 4'h4, 1'b1);   // MI
        run_cond(4'b1000, 4'h5, 1'b0);   // PL
        run_cond(4'b0001, 4'h6, 1'b1);   // VS
        run_cond(4'b0001, 4'h7, 1'b0);   // VC
        run_cond(4'b0010, 4'h8, 1'b1);   // HI
        run_cond(4'b0110, 4'h8, 1'b0);   // HI with Z
        run_cond(4'b0110, 4'h9, 1'b1);   // LS
        run_cond(4'b1001, 4'hA, 1'b1);   // GE
        run_cond(4'b1001, 4'hB, 1'b0);   // LT
        run_cond(4'b1000, 4'hB, 1'b1);   // LT
        run_cond(4'b0000, 4'hC, 1'b1);   // GT
        run_cond(4'b0100, 4'hC, 1'b0);   // GT with Z
        run_cond(4'b0100, 4'hD, 1'b1);   // LE
        run_cond(4'b0000, 4'hD, 1'b0);   // LE
        run_cond(4'b0000, 4'hE, 1'b1);   // AL
        run_cond(4'b1111, 4'hF, 1'b0);   // NV

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multicycle_controller
`default_nettype wire
